// File: rtl/wb_pipe_ram.sv
// Pipelined Wishbone B4 RAM with fixed ack latency and an outstanding-request limit.
// Optional pseudo-random stall injection is compiled in with WB_PIPE_RAM_STALL_INJECT_EN.
module wb_pipe_ram #(
    parameter int ADR_WIDTH = 32,
    parameter int DAT_WIDTH = 32,
    parameter int MEM_AW    = 10,
    parameter int LATENCY   = 2,
    parameter int MAX_OUTST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_cyc,
    input  logic                 wb_stb,
    input  logic                 wb_we,
    input  logic [ADR_WIDTH-1:0] wb_adr,
    input  logic [3:0]           wb_sel,
    input  logic [DAT_WIDTH-1:0] wb_dat_m,
    output logic                 wb_stall,
    output logic                 wb_ack,
    output logic [DAT_WIDTH-1:0] wb_dat_s
);
    localparam int         DEPTH   = 1 << MEM_AW;
    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

    logic [DAT_WIDTH-1:0] mem [DEPTH];
    logic [MEM_AW-1:0]    word_idx;
    logic                 accept;
    logic                 ack;
    logic                 stall_lim;
    logic                 stall_inj;
    logic [3:0]           outst_cnt;
    logic [LATENCY-1:0]   pipe_vld;
    logic [LATENCY-1:0]   pipe_rd;
    logic [DAT_WIDTH-1:0] pipe_dat [LATENCY];
    logic                 unused_adr;

    assign word_idx   = wb_adr[MEM_AW+1:2];
    assign unused_adr = ^{wb_adr[ADR_WIDTH-1:MEM_AW+2], wb_adr[1:0]};

    // An ack leaving the pipe frees a slot in the same cycle, so a full
    // counter only stalls when nothing retires.
    assign ack       = pipe_vld[LATENCY-1] & wb_cyc;
    assign stall_lim = (outst_cnt == MAX_CNT) & ~ack;
    assign wb_stall  = stall_lim | stall_inj;
    assign accept    = wb_cyc & wb_stb & ~wb_stall & ~rst;
    assign wb_ack    = ack;
    assign wb_dat_s  = (ack & pipe_rd[LATENCY-1]) ? pipe_dat[LATENCY-1] : '0;

`ifdef WB_PIPE_RAM_STALL_INJECT_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else if (wb_cyc) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall_inj = (lfsr[1:0] == 2'b00);
`else
    assign stall_inj = 1'b0;
`endif

    // Memory is deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept && wb_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_sel[b]) begin
                    mem[word_idx][8*b +: 8] <= wb_dat_m[8*b +: 8];
                end
            end
        end
    end

    // Read data is captured at acceptance and then just travels with the ack.
    always_ff @(posedge clk) begin
        if (rst || !wb_cyc) begin
            pipe_vld <= '0;
            pipe_rd  <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= accept;
            pipe_rd[0]  <= accept & ~wb_we;
            pipe_dat[0] <= (accept && !wb_we) ? mem[word_idx] : '0;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_rd[i]  <= pipe_rd[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !wb_cyc) begin
            outst_cnt <= '0;
        end else begin
            case ({accept, ack})
                2'b10:   outst_cnt <= outst_cnt + 4'd1;
                2'b01:   outst_cnt <= outst_cnt - 4'd1;
                default: outst_cnt <= outst_cnt;
            endcase
        end
    end

endmodule
